// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on/off events to NUM_VOICES voices (match, free, then steal oldest).
// Optional feature macro VOICE_ALLOC_STATS_EN adds a saturating steal_count output.
//
//   state  | meaning
//   IDLE   | waiting for an event, ev_ready high
//   SCAN   | examining one voice per cycle for match / free / oldest
//   COMMIT | applying the allocation decision to the chosen voice
//   GAP    | target key_on held low so Voice sees the envelope restart
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 7,
  parameter int GAP_CYCLES = 2048
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  output logic [NUM_VOICES-1:0]        voice_key_on,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
`ifdef VOICE_ALLOC_STATS_EN
  output logic [15:0]                  steal_count,
`endif
  output logic                         busy
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, GAP} state_t;
  state_t state, state_next;

  logic [NOTE_W-1:0] note_r [NUM_VOICES];
  logic [IW-1:0]     rank   [NUM_VOICES];
  logic              ev_on_q;
  logic [NOTE_W-1:0] ev_note_q;
  logic [IW-1:0]     idx, match_idx, free_idx, old_idx, target_q, target_c, promote_idx;
  logic              match_found, free_found, retrig_q;
  logic [GW-1:0]     gap_cnt;
  logic              accept, do_off, do_retrig, do_alloc, do_steal, gap_done, promote;

  assign accept      = ev_valid && ev_ready;
  assign busy        = (state != IDLE);
  assign promote     = do_alloc || do_steal || (gap_done && retrig_q);
  assign promote_idx = (state == GAP) ? target_q : target_c;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[g*NOTE_W +: NOTE_W] = note_r[g];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_off     = 1'b0;
    do_retrig  = 1'b0;
    do_alloc   = 1'b0;
    do_steal   = 1'b0;
    gap_done   = 1'b0;
    target_c   = old_idx;
    if (match_found)     target_c = match_idx;
    else if (free_found) target_c = free_idx;
    case (state)
      IDLE: if (accept) state_next = SCAN;
      SCAN: if (idx == LAST_IDX) state_next = COMMIT;
      COMMIT: begin
        if (!ev_on_q) begin
          do_off     = match_found;
          state_next = IDLE;
        end else if (match_found) begin
          do_retrig  = 1'b1;
          state_next = GAP;
        end else if (free_found) begin
          do_alloc   = 1'b1;
          state_next = IDLE;
        end else begin
          do_steal   = 1'b1;
          state_next = GAP;
        end
      end
      GAP: if (gap_cnt == '0) begin
        gap_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ev_ready     <= 1'b1;
      voice_key_on <= '0;
      ev_on_q      <= 1'b0;
      ev_note_q    <= '0;
      idx          <= '0;
      match_idx    <= '0;
      free_idx     <= '0;
      old_idx      <= '0;
      match_found  <= 1'b0;
      free_found   <= 1'b0;
      target_q     <= '0;
      retrig_q     <= 1'b0;
      gap_cnt      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_r[i] <= '0;
        rank[i]   <= IW'(i);
      end
    end else begin
      // Ready is held low through the cycle that returns to IDLE.
      ev_ready <= (state == IDLE) && !accept;
      if (accept) begin
        ev_on_q     <= ev_on;
        ev_note_q   <= ev_note;
        idx         <= '0;
        match_found <= 1'b0;
        free_found  <= 1'b0;
      end
      if (state == SCAN) begin
        if (voice_key_on[idx] && (note_r[idx] == ev_note_q) && !match_found) begin
          match_found <= 1'b1;
          match_idx   <= idx;
        end
        if (!voice_key_on[idx] && !free_found) begin
          free_found <= 1'b1;
          free_idx   <= idx;
        end
        if (rank[idx] == LAST_IDX) old_idx <= idx;
        idx <= idx + 1'b1;
      end
      if (state == COMMIT) begin
        target_q <= target_c;
        retrig_q <= do_retrig;
        gap_cnt  <= GAP_LOAD;
      end
      if ((state == GAP) && !gap_done) gap_cnt <= gap_cnt - 1'b1;
      if (do_off || do_retrig || do_steal) voice_key_on[target_c] <= 1'b0;
      if (do_alloc || gap_done) voice_key_on[promote_idx] <= 1'b1;
      // A stolen voice gets its new note in the same edge its gate drops.
      if (do_alloc || do_steal) note_r[target_c] <= ev_note_q;
      if (promote) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (IW'(i) == promote_idx)           rank[i] <= '0;
          else if (rank[i] < rank[promote_idx]) rank[i] <= rank[i] + 1'b1;
        end
      end
    end
  end

`ifdef VOICE_ALLOC_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n)                               steal_count <= '0;
    else if (do_steal && steal_count != 16'hFFFF) steal_count <= steal_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: table-driven event vectors with a scoreboard queue, plus reset-in-GAP and
// back-to-back handshake sequences.
module tb_voice_allocator;
  localparam int NV   = 4;
  localparam int NW   = 7;
  localparam int GAPC = 2048;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             ev_valid = 1'b0;
  logic             ev_on = 1'b0;
  logic [NW-1:0]    ev_note = '0;
  logic             ev_ready, busy;
  logic [NV-1:0]    voice_key_on;
  logic [NV*NW-1:0] voice_note;
`ifdef VOICE_ALLOC_STATS_EN
  logic [15:0]      steal_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic                 on;
    logic [NW-1:0]        note;
    logic [NV-1:0]        commit_key;
    logic [NV-1:0]        final_key;
    logic [NV-1:0][NW-1:0] notes;
    logic                 gap;
    int                   steals;
  } vec_t;

  vec_t vecs [12];
  vec_t bvec [4];
  vec_t sb [$];

  voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .GAP_CYCLES(GAPC)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .voice_key_on (voice_key_on),
    .voice_note   (voice_note),
`ifdef VOICE_ALLOC_STATS_EN
    .steal_count  (steal_count),
`endif
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ev_ready !== 1'b1 && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    if (ev_ready !== 1'b1) check("ready_timeout", 32'(ev_ready), 32'd1);
  endtask

  task automatic check_ranks(input string name);
    logic [NV-1:0] seen;
    seen = '0;
    for (int i = 0; i < NV; i++) seen[dut.rank[i]] = 1'b1;
    check(name, 32'(seen), 32'hF);
  endtask

  task automatic check_steals(input int exp);
`ifdef VOICE_ALLOC_STATS_EN
    check("steal_count", 32'(steal_count), 32'(exp));
`else
    if (exp < 0) $display("unexpected negative steal count");
`endif
  endtask

  task automatic run_vec(input vec_t v, input logic [NV-1:0] prev_key);
    vec_t e;
    wait_ready();
    ev_on    = v.on;
    ev_note  = v.note;
    ev_valid = 1'b1;
    sb.push_back(v);
    @(posedge Clk);
    @(negedge Clk);
    ev_valid = 1'b0;
    e = sb.pop_front();
    check("ready_low_after_accept", 32'(ev_ready), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    repeat (4) @(negedge Clk);
    check("key_hold_before_commit", 32'(voice_key_on), 32'(prev_key));
    @(negedge Clk);
    check("key_at_commit", 32'(voice_key_on), 32'(e.commit_key));
    check("notes_at_commit", 32'(voice_note), 32'(e.notes));
    check("ready_low_at_commit", 32'(ev_ready), 32'd0);
    if (e.gap) begin
      repeat (GAPC - 1) @(negedge Clk);
      check("key_low_end_of_gap", 32'(voice_key_on), 32'(e.commit_key));
      @(negedge Clk);
      check("key_after_gap", 32'(voice_key_on), 32'(e.final_key));
      check("notes_after_gap", 32'(voice_note), 32'(e.notes));
    end
    @(negedge Clk);
    check("ready_back", 32'(ev_ready), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    check_ranks("rank_permutation");
    check_steals(e.steals);
  endtask

  initial begin
    logic [NV-1:0] prev;
    vec_t e;
    vec_t after_rst;
    int n_acc, cyc, last;

    //               on    note   commit   final    notes {v3,v2,v1,v0}                 gap  steals
    vecs[0]  = '{1'b1, 7'h3C, 4'b0001, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h3C}, 1'b0, 0};
    vecs[1]  = '{1'b1, 7'h40, 4'b0011, 4'b0011, {7'h00, 7'h00, 7'h40, 7'h3C}, 1'b0, 0};
    vecs[2]  = '{1'b1, 7'h43, 4'b0111, 4'b0111, {7'h00, 7'h43, 7'h40, 7'h3C}, 1'b0, 0};
    vecs[3]  = '{1'b1, 7'h48, 4'b1111, 4'b1111, {7'h48, 7'h43, 7'h40, 7'h3C}, 1'b0, 0};
    vecs[4]  = '{1'b1, 7'h30, 4'b1110, 4'b1111, {7'h48, 7'h43, 7'h40, 7'h30}, 1'b1, 1};
    vecs[5]  = '{1'b0, 7'h40, 4'b1101, 4'b1101, {7'h48, 7'h43, 7'h40, 7'h30}, 1'b0, 1};
    vecs[6]  = '{1'b0, 7'h55, 4'b1101, 4'b1101, {7'h48, 7'h43, 7'h40, 7'h30}, 1'b0, 1};
    vecs[7]  = '{1'b1, 7'h43, 4'b1001, 4'b1101, {7'h48, 7'h43, 7'h40, 7'h30}, 1'b1, 1};
    vecs[8]  = '{1'b1, 7'h50, 4'b1111, 4'b1111, {7'h48, 7'h43, 7'h50, 7'h30}, 1'b0, 1};
    vecs[9]  = '{1'b1, 7'h3C, 4'b0111, 4'b1111, {7'h3C, 7'h43, 7'h50, 7'h30}, 1'b1, 2};
    vecs[10] = '{1'b0, 7'h30, 4'b1110, 4'b1110, {7'h3C, 7'h43, 7'h50, 7'h30}, 1'b0, 2};
    vecs[11] = '{1'b1, 7'h30, 4'b1111, 4'b1111, {7'h3C, 7'h43, 7'h50, 7'h30}, 1'b0, 2};
    after_rst = '{1'b1, 7'h22, 4'b0001, 4'b0001, {7'h00, 7'h00, 7'h00, 7'h22}, 1'b0, 0};
    bvec[0]  = '{1'b1, 7'h10, 4'b0011, 4'b0011, {7'h00, 7'h00, 7'h10, 7'h22}, 1'b0, 0};
    bvec[1]  = '{1'b1, 7'h11, 4'b0111, 4'b0111, {7'h00, 7'h11, 7'h10, 7'h22}, 1'b0, 0};
    bvec[2]  = '{1'b1, 7'h12, 4'b1111, 4'b1111, {7'h12, 7'h11, 7'h10, 7'h22}, 1'b0, 0};
    bvec[3]  = '{1'b0, 7'h22, 4'b1110, 4'b1110, {7'h12, 7'h11, 7'h10, 7'h22}, 1'b0, 0};

    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_key_on", 32'(voice_key_on), 32'd0);
    check("reset_notes", 32'(voice_note), 32'd0);
    check("reset_ready", 32'(ev_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_oldest_rank", 32'(dut.rank[NV-1]), 32'(NV - 1));
    check_steals(0);
    Reset_n = 1'b1;
    @(negedge Clk);

    prev = '0;
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], prev);
      prev = vecs[i].final_key;
    end

    // Steal of voice 2 (oldest), then reset while its gate is held low.
    wait_ready();
    ev_on = 1'b1;
    ev_note = 7'h11;
    ev_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    ev_valid = 1'b0;
    repeat (5) @(negedge Clk);
    check("steal_v2_commit_key", 32'(voice_key_on), 32'b1011);
    check("steal_v2_commit_notes", 32'(voice_note), 32'({7'h3C, 7'h11, 7'h50, 7'h30}));
    repeat (100) @(negedge Clk);
    check("mid_gap_key", 32'(voice_key_on), 32'b1011);
    check("mid_gap_busy", 32'(busy), 32'd1);
    Reset_n = 1'b0;
    @(negedge Clk);
    check("gap_reset_key_on", 32'(voice_key_on), 32'd0);
    check("gap_reset_notes", 32'(voice_note), 32'd0);
    check("gap_reset_ready", 32'(ev_ready), 32'd1);
    check("gap_reset_busy", 32'(busy), 32'd0);
    check_steals(0);
    Reset_n = 1'b1;
    @(negedge Clk);
    run_vec(after_rst, 4'b0000);

    // Back-to-back events with ev_valid held high.
    n_acc = 0;
    cyc = 0;
    last = 0;
    ev_on = bvec[0].on;
    ev_note = bvec[0].note;
    ev_valid = 1'b1;
    while (n_acc < 4 && cyc < 200) begin
      if (ev_ready === 1'b1) begin
        if (n_acc > 0) begin
          e = sb.pop_front();
          check("b2b_key", 32'(voice_key_on), 32'(e.final_key));
          check("b2b_notes", 32'(voice_note), 32'(e.notes));
          check("b2b_spacing", 32'(cyc - last), 32'd7);
          check_ranks("b2b_rank_permutation");
        end
        sb.push_back(bvec[n_acc]);
        last = cyc;
        @(posedge Clk);
        @(negedge Clk);
        cyc++;
        n_acc++;
        check("b2b_ready_dropped", 32'(ev_ready), 32'd0);
        if (n_acc < 4) begin
          ev_on = bvec[n_acc].on;
          ev_note = bvec[n_acc].note;
        end else begin
          ev_valid = 1'b0;
        end
      end else begin
        @(negedge Clk);
        cyc++;
      end
    end
    check("b2b_accept_count", 32'(n_acc), 32'd4);
    wait_ready();
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("b2b_final_key", 32'(voice_key_on), 32'(e.final_key));
      check("b2b_final_notes", 32'(voice_note), 32'(e.notes));
    end
    check("b2b_queue_empty", 32'(sb.size()), 32'd0);
    check_ranks("b2b_final_rank_permutation");
    check_steals(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
